// File: rtl/huffman_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_stream_ctrl
//  Purpose  : Feeds a HuffmanDecoder from a packed MSB-first word stream,
//             counts decoded symbols and ends the job after cfg_nsym symbols.
//  Revision : 1.0  initial release
// ============================================================================
module huffman_stream_ctrl #(
  parameter int WORD_W = 32,
  parameter int WIN_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_nsym,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_count,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIN_W-1:0]  encodedData,
  output logic              load,
  input  logic              ready,
  input  logic [3:0]        symbolLength,
  input  logic              decodedData_valid
);

  localparam int c_BUF_W  = 2 * WORD_W;
  localparam int c_BCNT_W = $clog2(c_BUF_W + 1);
  localparam logic [c_BCNT_W-1:0] c_WIN_N  = c_BCNT_W'(WIN_W);
  localparam logic [c_BCNT_W-1:0] c_WORD_N = c_BCNT_W'(WORD_W);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_PRIME = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_STALL = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [c_BUF_W-1:0]  r_buf;
  logic [c_BCNT_W-1:0] r_bcnt;
  logic [c_BCNT_W-1:0] r_need;
  logic [WIN_W-1:0]    r_win;
  logic                r_load;
  logic [CNT_W-1:0]    r_nsym;
  logic [CNT_W-1:0]    r_cnt;

  logic [2:0]          w_state_nxt;
  logic                w_stream_st;
  logic                w_accept;
  logic                w_term;
  logic                w_upd;
  logic                w_cap;
  logic                w_flush;
  logic [c_BCNT_W-1:0] w_req_ext;
  logic [c_BCNT_W-1:0] w_req_need;
  logic [c_BCNT_W-1:0] w_upd_need;
  logic [c_BCNT_W-1:0] w_bcnt_sh;
  logic [c_BUF_W-1:0]  w_buf_sh;
  logic [c_BUF_W-1:0]  w_word_al;
  logic [2*WIN_W-1:0]  w_win_cat;
  logic [WIN_W-1:0]    w_win_nxt;

  assign w_stream_st = (r_state == c_PRIME) || (r_state == c_RUN) || (r_state == c_STALL);
  assign in_ready    = w_stream_st && (r_bcnt <= c_WORD_N);
  assign w_accept    = in_valid && in_ready;
  assign w_term      = w_stream_st && decodedData_valid && ((r_cnt + CNT_W'(1)) == r_nsym);

  // Lengths at or above the window width (including the escape code) refill it completely
  assign w_req_ext  = c_BCNT_W'(symbolLength);
  assign w_req_need = (w_req_ext >= c_WIN_N) ? c_WIN_N : w_req_ext;

  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_cap       = 1'b0;
    w_upd_need  = '0;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_state_nxt = (cfg_nsym == '0) ? c_DONE : c_PRIME;
        end
      end
      c_PRIME: begin
        if (w_term) begin
          w_state_nxt = c_DONE;
        end else if (r_bcnt >= c_WIN_N) begin
          w_upd       = 1'b1;
          w_upd_need  = c_WIN_N;
          w_state_nxt = c_RUN;
        end
      end
      c_RUN: begin
        if (w_term) begin
          w_state_nxt = c_DONE;
        end else if (ready) begin
          if (r_bcnt >= w_req_need) begin
            w_upd      = 1'b1;
            w_upd_need = w_req_need;
          end else begin
            w_cap       = 1'b1;
            w_state_nxt = c_STALL;
          end
        end
      end
      c_STALL: begin
        if (w_term) begin
          w_state_nxt = c_DONE;
        end else if (r_bcnt >= r_need) begin
          w_upd       = 1'b1;
          w_upd_need  = r_need;
          w_state_nxt = c_RUN;
        end
      end
      c_DONE: begin
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Window slides left by the consumed bit count, taking new bits from the buffer head
  assign w_win_cat = {r_win, r_buf[c_BUF_W-1 -: WIN_W]};
  assign w_win_nxt = WIN_W'(w_win_cat >> (c_WIN_N - w_upd_need));

  assign w_buf_sh  = r_buf << w_upd_need;
  assign w_bcnt_sh = r_bcnt - w_upd_need;
  assign w_word_al = {in_word, {WORD_W{1'b0}}} >> w_bcnt_sh;
  assign w_flush   = (w_state_nxt == c_DONE) || (w_state_nxt == c_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_buf   <= '0;
      r_bcnt  <= '0;
      r_need  <= '0;
      r_win   <= '0;
      r_load  <= 1'b0;
      r_nsym  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_upd;
      if (w_upd) begin
        r_win <= w_win_nxt;
      end
      if (w_cap) begin
        r_need <= w_req_need;
      end
      if (w_flush) begin
        r_buf  <= '0;
        r_bcnt <= '0;
      end else if (w_accept) begin
        r_buf  <= w_buf_sh | w_word_al;
        r_bcnt <= w_bcnt_sh + c_WORD_N;
      end else begin
        r_buf  <= w_buf_sh;
        r_bcnt <= w_bcnt_sh;
      end
      if (r_state == c_IDLE) begin
        if (start) begin
          r_nsym <= cfg_nsym;
          r_cnt  <= '0;
        end
      end else if (decodedData_valid) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy        = (r_state != c_IDLE);
  assign done        = (r_state == c_DONE);
  assign sym_count   = r_cnt;
  assign encodedData = r_win;
  assign load        = r_load;

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huffman_stream_ctrl
//  Purpose  : Directed bench for huffman_stream_ctrl with a bit-queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_huffman_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_nsym;
  logic        busy;
  logic        done;
  logic [15:0] sym_count;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  encodedData;
  logic        load;
  logic        ready;
  logic [3:0]  symbolLength;
  logic        decodedData_valid;

  int n_checks = 0;
  int n_fail   = 0;

  huffman_stream_ctrl #(.WORD_W(32), .WIN_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_nsym(cfg_nsym),
    .busy(busy), .done(done), .sym_count(sym_count),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .encodedData(encodedData), .load(load), .ready(ready),
    .symbolLength(symbolLength), .decodedData_valid(decodedData_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: stream bits as a queue; the window is rebuilt one bit at a time.
  // Phases: 0 idle, 1 waiting for the first window, 2 running, 3 waiting for bits, 4 finished.
  bit          q[$];
  int          m_ph    = 0;
  int          m_wait  = 0;
  logic [5:0]  m_win   = '0;
  bit          m_ld    = 0;
  logic [15:0] m_cnt   = '0;
  logic [15:0] m_nsym  = '0;
  bit          m_valid = 0;

  function automatic int need_of(input int len);
    return (len >= 6) ? 6 : len;
  endfunction

  function automatic bit m_rdy();
    return (m_ph >= 1) && (m_ph <= 3) && (q.size() <= 32);
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit term;
    int n;
    acc  = in_valid && m_rdy();
    n    = -1;
    m_ld = 0;
    if (!rst) begin
      q.delete();
      m_ph    = 0;
      m_win   = '0;
      m_cnt   = '0;
      m_nsym  = '0;
      m_valid = 1;
    end else begin
      term = decodedData_valid && (m_ph >= 1) && (m_ph <= 3) && (16'(m_cnt + 1) == m_nsym);
      if (decodedData_valid && m_ph != 0) m_cnt = m_cnt + 16'd1;
      if (m_ph == 0) begin
        if (start) begin
          m_nsym = cfg_nsym;
          m_cnt  = '0;
          m_ph   = (cfg_nsym == 0) ? 4 : 1;
        end
      end else if (m_ph == 4) begin
        m_ph = 0;
      end else if (term) begin
        m_ph = 4;
      end else if (m_ph == 1) begin
        if (q.size() >= 6) n = 6;
      end else if (m_ph == 2) begin
        if (ready) begin
          if (q.size() >= need_of(int'(symbolLength))) n = need_of(int'(symbolLength));
          else begin
            m_wait = need_of(int'(symbolLength));
            m_ph   = 3;
          end
        end
      end else if (q.size() >= m_wait) begin
        n = m_wait;
      end
      if (n >= 0) begin
        repeat (n) m_win = {m_win[4:0], q.pop_front()};
        m_ld = 1;
        m_ph = 2;
      end
      if (acc) for (int i = 31; i >= 0; i--) q.push_back(in_word[i]);
      if (m_ph == 0 || m_ph == 4) q.delete();
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, m_ph != 0});
      chk("done", {31'b0, done}, {31'b0, m_ph == 4});
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy()});
      chk("load", {31'b0, load}, {31'b0, m_ld});
      chk("encodedData", {26'b0, encodedData}, {26'b0, m_win});
      chk("sym_count", {16'b0, sym_count}, {16'b0, m_cnt});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] len);
    ready = 1'b1;
    symbolLength = len;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; cfg_nsym = '0; in_word = '0; in_valid = 1'b0;
    ready = 1'b0; symbolLength = '0; decodedData_valid = 1'b0;
    step(); step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_enc", {26'b0, encodedData}, 32'd0);
    rst = 1'b1;

    // Job 1: prime, shifts, zero-length, escape, termination with dropped ready
    start = 1'b1; cfg_nsym = 16'd5; step();
    start = 1'b0;
    chk("j1_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_word = 32'hA5A5A5A5; step();
    in_valid = 1'b0;
    chk("j1_no_load_yet", {31'b0, load}, 32'd0);
    step();
    chk("j1_prime_load", {31'b0, load}, 32'd1);
    chk("j1_prime_enc", {26'b0, encodedData}, 32'h29);
    chk("j1_prime_bits", q.size(), 32'd26);
    req(4'd4);
    chk("j1_shift4", {26'b0, encodedData}, 32'h16);
    req(4'd1);
    chk("j1_shift1", {26'b0, encodedData}, 32'h2D);
    req(4'd0);
    chk("j1_len0_load", {31'b0, load}, 32'd1);
    chk("j1_len0_enc", {26'b0, encodedData}, 32'h2D);
    req(4'd10);
    chk("j1_escape_enc", {26'b0, encodedData}, 32'h0B);
    chk("j1_escape_bits", q.size(), 32'd15);
    ready = 1'b0;
    decodedData_valid = 1'b1;
    repeat (4) step();
    ready = 1'b1; symbolLength = 4'd3; step();
    ready = 1'b0; decodedData_valid = 1'b0;
    chk("j1_done", {31'b0, done}, 32'd1);
    chk("j1_drop_load", {31'b0, load}, 32'd0);
    chk("j1_count", {16'b0, sym_count}, 32'd5);
    step();
    chk("j1_idle", {31'b0, busy}, 32'd0);

    // Job 2: escape from fresh window, stall and recovery, reset during stall
    start = 1'b1; cfg_nsym = 16'd20; step();
    start = 1'b0;
    in_valid = 1'b1; in_word = 32'hA5A5A5A7; step();
    in_valid = 1'b0; step();
    chk("j2_prime_enc", {26'b0, encodedData}, 32'h29);
    req(4'd10);
    chk("j2_escape_enc", {26'b0, encodedData}, 32'h1A);
    chk("j2_escape_bits", q.size(), 32'd20);
    repeat (3) req(4'd6);
    chk("j2_low_bits", q.size(), 32'd2);
    req(4'd6);
    chk("j2_stall_load", {31'b0, load}, 32'd0);
    chk("j2_stall_in_ready", {31'b0, in_ready}, 32'd1);
    symbolLength = 4'd1;
    in_valid = 1'b1; in_word = 32'hFFFFFFFF; step();
    in_valid = 1'b0;
    chk("j2_accept_no_load", {31'b0, load}, 32'd0);
    step();
    chk("j2_recover_load", {31'b0, load}, 32'd1);
    chk("j2_recover_enc", {26'b0, encodedData}, 32'h3F);
    ready = 1'b0; step();
    repeat (4) req(4'd6);
    req(4'd6);
    ready = 1'b0;
    chk("j2_stall2_load", {31'b0, load}, 32'd0);
    rst = 1'b0; step();
    chk("j2_rst_busy", {31'b0, busy}, 32'd0);
    chk("j2_rst_enc", {26'b0, encodedData}, 32'd0);
    chk("j2_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;

    // Job 3: fresh prime after reset, ignored restart, three-symbol termination
    start = 1'b1; cfg_nsym = 16'd3; step();
    start = 1'b0;
    in_valid = 1'b1; in_word = 32'h12345678; step();
    in_valid = 1'b0; step();
    chk("j3_fresh_enc", {26'b0, encodedData}, 32'h04);
    start = 1'b1; cfg_nsym = 16'd7; step();
    start = 1'b0;
    decodedData_valid = 1'b1;
    repeat (3) step();
    decodedData_valid = 1'b0;
    chk("j3_done", {31'b0, done}, 32'd1);
    chk("j3_count", {16'b0, sym_count}, 32'd3);
    step();
    chk("j3_idle", {31'b0, busy}, 32'd0);
    decodedData_valid = 1'b1; step();
    decodedData_valid = 1'b0;
    chk("j3_idle_valid_ignored", {16'b0, sym_count}, 32'd3);

    // Job 4: zero symbols
    start = 1'b1; cfg_nsym = 16'd0; step();
    start = 1'b0;
    chk("j4_done", {31'b0, done}, 32'd1);
    chk("j4_no_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("j4_idle", {31'b0, busy}, 32'd0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
